// File: rtl/mem_block_responder.sv
// mem_block_responder
//   Memory-side responder for the cache's 128-bit block interface. Holds a DEPTH x 128-bit
//   block store. Each accepted read or write finishes LATENCY cycles after acceptance with a
//   one-cycle mem_ready pulse. This is the system memory model below the L2 cache.
//
// Ports
//   clk          in   rising-edge clock
//   mem_reset_n  in   asynchronous active-low reset
//   mem_read     in   read request, held by the cache until mem_ready
//   mem_write    in   write request, held by the cache until mem_ready
//   mem_addr     in   28-bit block address; only [ADDR_W-1:0] is used, so upper bits alias
//   mem_wdata    in   128-bit write block
//   mem_rdata    out  128-bit read block, registered, held until the next read completes
//   mem_ready    out  one-cycle completion pulse
//   mem_err      out  sticky protocol-error flag (only when MEM_RESP_CHECK_EN is defined)
//
// Configuration
//   MEM_RESP_CHECK_EN  when defined, adds mem_err and the protocol checker.
//                      When undefined, there is no mem_err port and no checker.

module mem_block_responder #(
    parameter int unsigned LATENCY = 4,     // 1..255
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DEPTH   = 1024   // must equal 2**ADDR_W
) (
    input  logic         clk,
    input  logic         mem_reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready
`ifdef MEM_RESP_CHECK_EN
    ,
    output logic         mem_err
`endif
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    localparam logic [7:0] CntInit = 8'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                op_write_q, op_write_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [127:0]        wdata_q, wdata_d;
    logic [127:0]        rdata_q, rdata_d;
    logic [127:0]        store_q [DEPTH];

    logic                req;
    logic                commit;
    logic                commit_write;
    logic [ADDR_W-1:0]   commit_idx;
    logic [127:0]        commit_wdata;

    // Upper address bits are deliberately dropped (block aliasing).
    logic unused_addr;
    assign unused_addr = ^mem_addr[27:ADDR_W];

    assign req = mem_read | mem_write;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_write_d   = op_write_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        commit       = 1'b0;
        commit_write = op_write_q;
        commit_idx   = idx_q;
        commit_wdata = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    // Read and write together is treated as a write.
                    op_write_d = mem_write;
                    idx_d      = mem_addr[ADDR_W-1:0];
                    wdata_d    = mem_wdata;
                    cnt_d      = CntInit;
                    if (LATENCY == 1) begin
                        // Acceptance edge is also the commit edge, so use the live inputs.
                        state_d      = StResp;
                        commit       = 1'b1;
                        commit_write = mem_write;
                        commit_idx   = mem_addr[ADDR_W-1:0];
                        commit_wdata = mem_wdata;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rdata_d = (commit && !commit_write) ? store_q[commit_idx] : rdata_q;
    end

    always_ff @(posedge clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // Block store is not reset. Gating on reset keeps an aborted write from landing.
    always_ff @(posedge clk) begin
        if (mem_reset_n && commit && commit_write) begin
            store_q[commit_idx] <= commit_wdata;
        end
    end

    assign mem_ready = (state_q == StResp);
    assign mem_rdata = rdata_q;

`ifdef MEM_RESP_CHECK_EN
    logic        err_q, err_d;
    logic [27:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (state_q == StIdle && req) begin
            addr_d = mem_addr;
        end
        err_d = err_q
              | (mem_read & mem_write)
              | ((state_q == StBusy) && req && (mem_addr != addr_q));
    end

    always_ff @(posedge clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            err_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            err_q  <= err_d;
            addr_q <= addr_d;
        end
    end

    assign mem_err = err_q;
`endif

endmodule

// File: tb/tb_mem_block_responder.sv
module tb_mem_block_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd, wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         rdy;

    logic         r1_rd, r1_wr;
    logic [27:0]  r1_addr;
    logic [127:0] r1_wdata;
    logic [127:0] r1_rdata;
    logic         r1_rdy;

`ifdef MEM_RESP_CHECK_EN
    logic         err;
    logic         r1_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_block_responder #(.LATENCY(4), .ADDR_W(10), .DEPTH(1024)) dut (
        .clk         (clk),
        .mem_reset_n (rst_n),
        .mem_read    (rd),
        .mem_write   (wr),
        .mem_addr    (addr),
        .mem_wdata   (wdata),
        .mem_rdata   (rdata),
        .mem_ready   (rdy)
`ifdef MEM_RESP_CHECK_EN
        ,
        .mem_err     (err)
`endif
    );

    mem_block_responder #(.LATENCY(1), .ADDR_W(10), .DEPTH(1024)) dut1 (
        .clk         (clk),
        .mem_reset_n (rst_n),
        .mem_read    (r1_rd),
        .mem_write   (r1_wr),
        .mem_addr    (r1_addr),
        .mem_wdata   (r1_wdata),
        .mem_rdata   (r1_rdata),
        .mem_ready   (r1_rdy)
`ifdef MEM_RESP_CHECK_EN
        ,
        .mem_err     (r1_err)
`endif
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic w, input logic [27:0] a, input logic [127:0] d);
        rd    = !w;
        wr    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle_req();
        rd = 1'b0;
        wr = 1'b0;
    endtask

    // Counts edges until mem_ready is seen; the first counted edge is the acceptance edge.
    task automatic wait_ready(input string tag, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 300);
        if (!rdy) check_eq({tag, " timeout"}, 128'd0, 128'd1);
    endtask

    // Full transaction from an idle DUT, called #1 after a rising edge.
    task automatic xact(input string tag, input logic w, input logic [27:0] a,
                        input logic [127:0] d, input int exp_n);
        int n;
        start_req(w, a, d);
        wait_ready(tag, n);
        check_eq({tag, " latency"}, 128'(n), 128'(exp_n));
        idle_req();
        @(posedge clk);
        #1;
        check_eq({tag, " single pulse"}, 128'(rdy), 128'd0);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        addr     = '0;
        wdata    = '0;
        r1_rd    = 1'b0;
        r1_wr    = 1'b0;
        r1_addr  = '0;
        r1_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset ready", 128'(rdy), 128'd0);
        check_eq("reset rdata", rdata, 128'd0);
`ifdef MEM_RESP_CHECK_EN
        check_eq("reset err", 128'(err), 128'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LATENCY=1 instance: ready on the acceptance edge itself.
        r1_wr = 1'b1; r1_addr = 28'h007; r1_wdata = {16{8'h5A}};
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!r1_rdy && n < 300);
        check_eq("lat1 write latency", 128'(n), 128'd1);
        r1_wr = 1'b0;
        @(posedge clk); #1;
        check_eq("lat1 single pulse", 128'(r1_rdy), 128'd0);
        r1_rd = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!r1_rdy && n < 300);
        check_eq("lat1 read latency", 128'(n), 128'd1);
        check_eq("lat1 read data", r1_rdata, {16{8'h5A}});
        r1_rd = 1'b0;
        @(posedge clk); #1;

        // Basic write then read.
        xact("wr 005", 1'b1, 28'h005, {16{8'hA5}}, 4);
        check_eq("rdata unchanged by write", rdata, 128'd0);
        xact("rd 005", 1'b0, 28'h005, '0, 4);
        check_eq("rd 005 data", rdata, {16{8'hA5}});

        // Write-back then refill with no idle gap.
        start_req(1'b1, 28'h3FF, {16{8'hD1}});
        wait_ready("wr 3ff", n);
        check_eq("wr 3ff latency", 128'(n), 128'd4);
        start_req(1'b0, 28'h3FF, '0);
        wait_ready("b2b rd 3ff", n);
        check_eq("b2b rd latency", 128'(n), 128'd5);
        check_eq("b2b rd data", rdata, {16{8'hD1}});
        idle_req();
        @(posedge clk); #1;
        check_eq("b2b single pulse", 128'(rdy), 128'd0);

        // Aliasing: 0x400 maps to block 0.
        xact("wr 400", 1'b1, 28'h400, {16{8'hC3}}, 4);
        check_eq("rdata held", rdata, {16{8'hD1}});
        xact("rd 000", 1'b0, 28'h000, '0, 4);
        check_eq("alias data", rdata, {16{8'hC3}});

        // Request dropped and inputs changed after acceptance.
        start_req(1'b1, 28'h020, {16{8'h77}});
        @(posedge clk); #1;
        idle_req();
        addr  = 28'h021;
        wdata = {16{8'h88}};
        wait_ready("dropped wr", n);
        check_eq("dropped wr latency", 128'(n), 128'd3);
        @(posedge clk); #1;
        xact("rd 020", 1'b0, 28'h020, '0, 4);
        check_eq("dropped wr data", rdata, {16{8'h77}});

        // Read and write together for one cycle: treated as write.
        start_req(1'b1, 28'h028, {16{8'h99}});
        rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        wait_ready("rw wr", n);
        check_eq("rw latency", 128'(n), 128'd3);
        idle_req();
        @(posedge clk); #1;
`ifdef MEM_RESP_CHECK_EN
        check_eq("err set", 128'(err), 128'd1);
`endif
        xact("rd 028", 1'b0, 28'h028, '0, 4);
        check_eq("rw data", rdata, {16{8'h99}});
`ifdef MEM_RESP_CHECK_EN
        check_eq("err sticky", 128'(err), 128'd1);
`endif

        // Reset mid-write: write aborted, no pulse.
        xact("wr 010", 1'b1, 28'h010, {16{8'h11}}, 4);
        start_req(1'b1, 28'h010, {16{8'hEE}});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid reset ready", 128'(rdy), 128'd0);
        check_eq("mid reset rdata", rdata, 128'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("in reset ready", 128'(rdy), 128'd0);
        end
        idle_req();
        @(posedge clk); #1;
        rst_n = 1'b1;
`ifdef MEM_RESP_CHECK_EN
        check_eq("err cleared", 128'(err), 128'd0);
`endif
        @(posedge clk); #1;
        xact("rd 010", 1'b0, 28'h010, '0, 4);
        check_eq("aborted wr data", rdata, {16{8'h11}});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
